regfile_wb_arbiter: RTL and testbench

Writeback arbiter that shares the architectural register file's write ports among several result producers (ALU, load unit, mul/div). Each producer pushes into a private FIFO. Every cycle the block grants up to WRITE_PORTS FIFO heads in round-robin order and drives them onto the regfile write interface (`wa`/`wd`/`valid`). It also exports a per-register pending mask so issue logic can hold readers of registers whose writes are still buffered.

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter sharing regfile write ports among per-producer FIFOs.
// Define REGFILE_WB_ARB_BYPASS_EN to let a producer with an empty FIFO reach wb_* in the same cycle.
module regfile_wb_arbiter #(
   parameter int NUM_SRC     = 3,
   parameter int WRITE_PORTS = 2,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   output logic [NUM_SRC-1:0]            src_ready,
   input  logic [NUM_SRC-1:0][4:0]       src_wa,
   input  logic [NUM_SRC-1:0][63:0]      src_wd,
   output logic [WRITE_PORTS-1:0]        wb_valid,
   output logic [WRITE_PORTS-1:0][4:0]   wb_wa,
   output logic [WRITE_PORTS-1:0][63:0]  wb_wd,
   output logic [31:0]                   pending
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
   logic [4:0]                           wa_q [NUM_SRC][FIFO_DEPTH];
   logic [63:0]                          wd_q [NUM_SRC][FIFO_DEPTH];
   logic [NUM_SRC-1:0][FIFO_DEPTH-1:0]   vld;
   logic [NUM_SRC-1:0][AW-1:0]           rd_ptr, wr_ptr;
   logic [SW-1:0]                        rr_ptr, rr_d;
   logic [NUM_SRC-1:0]                   pop, byp, push;

   // Per-slot valid bits: full/empty fall out directly, no separate count needed.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = ~&vld[i];
         push[i] = src_valid[i] && src_ready[i] && src_wa[i] != 5'd0 && !byp[i];
      end
   end

   always_comb begin
      int n, idx, last;
      logic cand, hit;
      logic [4:0] ca;
      logic [63:0] cd;
      wb_valid = '0;
      wb_wa = '0;
      wb_wd = '0;
      pop = '0;
      byp = '0;
      n = 0;
      last = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_SRC) idx -= NUM_SRC;
         cand = |vld[idx];
         ca = wa_q[idx][rd_ptr[idx]];
         cd = wd_q[idx][rd_ptr[idx]];
`ifdef REGFILE_WB_ARB_BYPASS_EN
         if (!cand && src_valid[idx] && src_wa[idx] != 5'd0) begin
            cand = 1'b1;
            ca = src_wa[idx];
            cd = src_wd[idx];
         end
`endif
         hit = 1'b0;
         for (int j = 0; j < WRITE_PORTS; j++) hit |= wb_valid[j] && wb_wa[j] == ca;
         if (cand && !hit && n < WRITE_PORTS) begin
            wb_valid[n] = 1'b1;
            wb_wa[n] = ca;
            wb_wd[n] = cd;
            pop[idx] = |vld[idx];
            byp[idx] = ~|vld[idx];
            last = idx;
            n++;
         end
      end
      rr_d = last < 0 ? rr_ptr : (last + 1 == NUM_SRC ? '0 : SW'(last + 1));
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < NUM_SRC; i++)
         for (int e = 0; e < FIFO_DEPTH; e++)
            if (vld[i][e]) pending[wa_q[i][e]] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
         vld <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         rr_ptr <= rr_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
               vld[i][wr_ptr[i]] <= 1'b1;
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) begin
               vld[i][rd_ptr[i]] <= 1'b0;
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++)
         if (push[i]) begin
            wa_q[i][wr_ptr[i]] <= src_wa[i];
            wd_q[i][wr_ptr[i]] <= src_wd[i];
         end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: queue-based reference model with directed scenarios and random traffic.
module tb_regfile_wb_arbiter;
   localparam int NS = 3, WP = 2, D = 2;
   logic                   clk = 1'b0, reset = 1'b1;
   logic [NS-1:0]          src_valid, src_ready;
   logic [NS-1:0][4:0]     src_wa;
   logic [NS-1:0][63:0]    src_wd;
   logic [WP-1:0]          wb_valid;
   logic [WP-1:0][4:0]     wb_wa;
   logic [WP-1:0][63:0]    wb_wd;
   logic [31:0]            pending;
   int                     total = 0, bad = 0;
   logic [68:0]            q [NS][$];
   int                     m_rr = 0, last, sent;
   logic [NS-1:0]          gnt, acc, e_rdy;
   logic [WP-1:0]          e_v;
   logic [WP-1:0][4:0]     e_a;
   logic [WP-1:0][63:0]    e_d;
   logic [31:0]            e_p;
   logic [63:0]            seen9 [$];
   int                     gcnt [32];
   logic [NS-1:0]          r_v;
   logic [NS-1:0][4:0]     r_a;
   logic [NS-1:0][63:0]    r_d;

   regfile_wb_arbiter #(.NUM_SRC(NS), .WRITE_PORTS(WP), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
      .src_wa(src_wa), .src_wd(src_wd), .wb_valid(wb_valid), .wb_wa(wb_wa),
      .wb_wd(wb_wd), .pending(pending));

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < NS; s++) q[s].delete();
      m_rr = 0;
   endfunction

   // Expected outputs for the current buffered state: scan from m_rr, skip duplicate addresses.
   function automatic void model_eval();
      int n, s;
      logic dup;
      logic [68:0] h;
      e_v = '0; e_a = '0; e_d = '0; e_p = '0; gnt = '0; n = 0; last = -1;
      for (int k = 0; k < NS; k++) begin
         s = (m_rr + k) % NS;
         e_rdy[s] = q[s].size() < D;
         for (int e = 0; e < q[s].size(); e++) e_p[q[s][e][68:64]] = 1'b1;
         if (q[s].size() == 0 || n == WP) continue;
         h = q[s][0];
         dup = 1'b0;
         for (int j = 0; j < n; j++) if (e_a[j] == h[68:64]) dup = 1'b1;
         if (dup) continue;
         e_v[n] = 1'b1; e_a[n] = h[68:64]; e_d[n] = h[63:0];
         gnt[s] = 1'b1; last = s; n++;
      end
   endfunction

   function automatic void model_step();
      acc = '0;
      if (!reset) begin
         model_clear();
         return;
      end
      for (int s = 0; s < NS; s++) begin
         if (gnt[s]) void'(q[s].pop_front());
         acc[s] = src_valid[s] && e_rdy[s];
         if (acc[s] && src_wa[s] != 5'd0) q[s].push_back({src_wa[s], src_wd[s]});
      end
      if (last >= 0) m_rr = (last + 1) % NS;
   endfunction

   task automatic cyc(input logic rv, input logic [NS-1:0] v, input logic [NS-1:0][4:0] a,
                      input logic [NS-1:0][63:0] d);
      @(negedge clk);
      model_eval();
      chk("wb_valid", wb_valid, e_v);
      chk("wb_wa", wb_wa, e_a);
      chk("wb_wd", wb_wd, e_d);
      chk("pending", pending, e_p);
      chk("src_ready", src_ready, e_rdy);
      for (int j = 0; j < WP; j++)
         if (wb_valid[j]) begin
            gcnt[wb_wa[j]]++;
            if (wb_wa[j] == 5'd9) seen9.push_back(wb_wd[j]);
         end
      reset = rv; src_valid = v; src_wa = a; src_wd = d;
      if (!rv) begin
         model_clear();
         model_eval();
      end
      #1;
      chk("wb_no_src_path", {wb_valid, wb_wa}, {e_v, e_a});
      chk("wd_no_src_path", wb_wd, e_d);
      @(posedge clk);
      model_step();
   endtask

   task automatic rnd();
      for (int s = 0; s < NS; s++) begin
         r_v[s] = $urandom_range(0, 9) < 7;
         r_a[s] = 5'($urandom_range(0, 7));
         r_d[s] = {$urandom, $urandom};
      end
   endtask

   task automatic rst_seq();
      cyc(1'b0, '0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      src_valid = '0; src_wa = '0; src_wd = '0;
      #2 reset = 1'b0;
      repeat (3) begin
         rnd();
         cyc(1'b0, r_v, r_a, r_d);
         #1 chk("rst_hold", {wb_valid, pending, src_ready}, {2'b00, 32'h0, 3'b111});
      end
      // Fairness: continuous distinct writes rotate grants {0,1},{2,0},{1,2}
      for (int i = 0; i < 32; i++) gcnt[i] = 0;
      cyc(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {64'd3, 64'd2, 64'd1});
      #1 chk("fair_c1", {wb_valid, wb_wa}, {2'b11, 5'd2, 5'd1});
      cyc(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {64'd3, 64'd2, 64'd1});
      #1 chk("fair_c2", {wb_valid, wb_wa}, {2'b11, 5'd1, 5'd3});
      cyc(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {64'd3, 64'd2, 64'd1});
      #1 chk("fair_c3", {wb_valid, wb_wa}, {2'b11, 5'd3, 5'd2});
      repeat (4) cyc(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {64'd3, 64'd2, 64'd1});
      for (int s = 1; s <= 3; s++) chk("fair_share", 128'(gcnt[s]), 128'd4);
      // Same-address conflict
      rst_seq();
      cyc(1'b1, 3'b011, {5'd0, 5'd5, 5'd5}, {64'd0, 64'hB, 64'hA});
      #1 chk("conf_c1", {wb_valid, wb_wa, wb_wd[0]}, {2'b01, 5'd0, 5'd5, 64'hA});
      chk("conf_pend1", pending, 32'h20);
      cyc(1'b1, '0, '0, '0);
      #1 chk("conf_c2", {wb_valid, wb_wa, wb_wd[0]}, {2'b01, 5'd0, 5'd5, 64'hB});
      chk("conf_pend2", pending, 32'h20);
      cyc(1'b1, '0, '0, '0);
      #1 chk("conf_c3", {wb_valid, pending}, 34'h0);
      // Backpressure on src2 while src0/src1 saturate the ports
      rst_seq();
      seen9.delete();
      sent = 0;
      for (int c = 0; c < 12 && sent < 3; c++) begin
         cyc(1'b1, {1'b1, 1'b1, 1'b1}, {5'd9, 5'd2, 5'd1}, {64'(sent + 1), 64'd2, 64'd1});
         if (acc[2]) begin
            sent++;
            #1;
            if (sent == 2) chk("bp_ready_drop", 128'(src_ready[2]), 128'd0);
            if (sent == 3) chk("bp_pending_held", 128'(pending[9]), 128'd1);
         end
      end
      chk("bp_accepts", 128'(sent), 128'd3);
      repeat (8) cyc(1'b1, '0, '0, '0);
      chk("bp_count", 128'(seen9.size()), 128'd3);
      for (int i = 0; i < 3; i++) chk("bp_order", i < seen9.size() ? seen9[i] : 64'hFFFF, 128'(i + 1));
      #1 chk("bp_drained", pending, 32'h0);
      // x0 writes are accepted and dropped
      rst_seq();
      cyc(1'b1, 3'b010, {5'd0, 5'd0, 5'd0}, {64'd0, 64'hDEAD, 64'd0});
      #1 chk("x0_none", {wb_valid, pending, src_ready}, {2'b00, 32'h0, 3'b111});
      cyc(1'b1, '0, '0, '0);
      #1 chk("x0_none2", {wb_valid, pending}, 34'h0);
      // Latency without bypass: visible one cycle after the push
      rst_seq();
      cyc(1'b1, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 64'd0, 64'h1234});
      #1 chk("lat_c1", {wb_valid, wb_wa[0], wb_wd[0]}, {2'b01, 5'd7, 64'h1234});
      // Random traffic with a mid-run reset
      rst_seq();
      for (int c = 0; c < 600; c++) begin
         rnd();
         cyc(c == 300 ? 1'b0 : 1'b1, r_v, r_a, r_d);
      end
      repeat (6) cyc(1'b1, '0, '0, '0);
      #1 chk("final_empty", {wb_valid, pending}, 34'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
